// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//
// Write-side front end for the 32x32 register file. It owns the single write
// port and merges two writeback sources:
//   - ALU results: single cycle, always accepted, highest priority.
//   - LSU results: valid/ready handshake into a DEPTH-entry FIFO, drained
//     whenever the ALU is not writing.
// A pending-write scoreboard tracks long-latency destinations from issue
// until their FIFO entry is written back.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU writeback (no backpressure)
//   lsu_valid/lsu_ready           LSU writeback handshake
//   lsu_rd/lsu_data               LSU writeback payload
//   issue_valid/issue_rd          long-latency op issued, sets pending bit
//   w_en/addr_w/w_data            registered register-file write port
//   pending                       bit i set while a write to xi is outstanding
//   fifo_count                    current LSU FIFO occupancy (0..DEPTH)

module regfile_writeback_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,

    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_W-1:0]          lsu_rd,
    input  logic [DATA_W-1:0]          lsu_data,

    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,

    output logic                       w_en,
    output logic [ADDR_W-1:0]          addr_w,
    output logic [DATA_W-1:0]          w_data,

    output logic [31:0]                pending,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // FIFO storage; contents need no reset, occupancy is tracked by count_q.
    logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q,  count_d;

    logic              w_en_q,   w_en_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [31:0]       pending_q, pending_d;

    logic              fifo_empty;
    logic              alu_win;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign lsu_ready  = (count_q != CntW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // A write to x0 is dropped and must not steal the port from the FIFO.
    assign alu_win = alu_valid && (alu_rd != '0);
    assign pop     = !alu_win && !fifo_empty;
    // Handshakes targeting x0 complete but enqueue nothing.
    assign push    = lsu_valid && lsu_ready && (lsu_rd != '0);

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write port: ALU first, then FIFO head; idle holds address and data.
    always_comb begin
        w_en_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;

        if (alu_win) begin
            w_en_d = 1'b1;
            addr_d = alu_rd;
            data_d = alu_data;
        end else if (pop) begin
            w_en_d = 1'b1;
            addr_d = head_rd;
            data_d = head_data;
        end
    end

    // Scoreboard: clear on FIFO writeback, set on issue; set wins on collision.
    // Only the low five bits of rd select the bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;

        if (issue_valid && (issue_rd != '0)) begin
            set_mask = 32'(1) << issue_rd[4:0];
        end
        if (pop) begin
            clr_mask = 32'(1) << head_rd[4:0];
        end

        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            w_en_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            w_en_q    <= w_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_rd_q[wr_ptr_q]   <= lsu_rd;
            fifo_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign w_en       = w_en_q;
    assign addr_w     = addr_q;
    assign w_data     = data_q;
    assign pending    = pending_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              w_en;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] w_data;
    logic [31:0]       pending;
    logic [CNT_W-1:0]  fifo_count;

    regfile_writeback_arbiter #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .w_en       (w_en),
        .addr_w     (addr_w),
        .w_data     (w_data),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of queued writebacks, a bit-per-register pending
    // array and the last value presented on the write port.
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t               q[$];
    bit                m_pend[32];
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_step();
        bit  ready;
        wb_t e;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
            m_wen  = 1'b0;
            m_addr = '0;
            m_data = '0;
            return;
        end
        ready = (q.size() != DEPTH);
        if (alu_valid && alu_rd != 0) begin
            m_wen  = 1'b1;
            m_addr = alu_rd;
            m_data = alu_data;
        end else if (q.size() > 0) begin
            e      = q.pop_front();
            m_wen  = 1'b1;
            m_addr = e.rd;
            m_data = e.data;
            m_pend[e.rd % 32] = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (lsu_valid && ready && lsu_rd != 0) begin
            e.rd   = lsu_rd;
            e.data = lsu_data;
            q.push_back(e);
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd % 32] = 1;
        m_pend[0] = 0;
    endtask

    task automatic compare_all();
        check("w_en",       64'(w_en),       64'(m_wen));
        check("addr_w",     64'(addr_w),     64'(m_addr));
        check("w_data",     64'(w_data),     64'(m_data));
        check("pending",    64'(pending),    64'(model_pending()));
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
        check("lsu_ready",  64'(lsu_ready),  64'(q.size() != DEPTH));
    endtask

    // Called at a negedge with inputs already set: apply one posedge, then
    // compare every output at the following negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();

        // Reset then idle; reset held with ALU traffic must not write.
        idle_inputs();
        tick();
        check("idle_ready", 64'(lsu_ready), 64'd1);
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 6'd4; alu_data = 32'h1111_2222;
        tick();
        check("rst_alu_no_wen", 64'(w_en), 64'd0);
        idle_inputs();

        // ALU write latency.
        alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        check("alu_wen", 64'(w_en), 64'd1);
        check("alu_addr", 64'(addr_w), 64'd5);
        check("alu_data", 64'(w_data), 64'hDEAD_BEEF);
        idle_inputs();
        tick();
        check("alu_wen_drop", 64'(w_en), 64'd0);

        // Scoreboard set by issue, cleared when the LSU result is written.
        issue_valid = 1'b1; issue_rd = 6'd7;
        tick();
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 6'd7; lsu_data = 32'h1234_5678;
        tick();
        check("pend7_held", 64'(pending[7]), 64'd1);
        idle_inputs();
        tick();
        check("lsu_wen", 64'(w_en), 64'd1);
        check("lsu_addr", 64'(addr_w), 64'd7);
        check("pend7_clr", 64'(pending[7]), 64'd0);

        // ALU starves the FIFO until it fills; drains in order afterwards.
        alu_valid = 1'b1; alu_rd = 6'd3; alu_data = 32'hA5A5_0003;
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1'b1; lsu_rd = ADDR_W'(8 + i); lsu_data = 32'hC000_0000 + i;
            tick();
        end
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(lsu_ready), 64'd0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_addr", 64'(addr_w), 64'(8 + i));
            if (i == 0) check("ready_after_pop", 64'(lsu_ready), 64'd1);
        end

        // x0 handshake enqueues nothing; ALU x0 does not block a pop.
        lsu_valid = 1'b1; lsu_rd = 6'd0; lsu_data = 32'hFFFF_FFFF;
        tick();
        check("x0_no_enq", 64'(fifo_count), 64'd0);
        lsu_rd = 6'd2; lsu_data = 32'h0000_0222;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 6'd0; alu_data = 32'hBAD0_BAD0;
        tick();
        check("alu_x0_pop_addr", 64'(addr_w), 64'd2);
        check("alu_x0_pop_wen", 64'(w_en), 64'd1);

        // Set wins over a same-cycle clear.
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 6'd9;
        tick();
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 6'd9; lsu_data = 32'h0000_0999;
        tick();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 6'd9;
        tick();
        check("set_wins", 64'(pending[9]), 64'd1);

        // Reset with queued entries discards them.
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 6'd1; alu_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = ADDR_W'(20 + i); lsu_data = 32'h20 + i;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_wen", 64'(w_en), 64'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            alu_valid   = ($urandom_range(0, 99) < 35);
            alu_rd      = ($urandom_range(0, 7) == 0) ? 6'd0 : ADDR_W'($urandom_range(1, 31));
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 99) < 50);
            lsu_rd      = ($urandom_range(0, 7) == 0) ? 6'd0 : ADDR_W'($urandom_range(1, 31));
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rd    = ADDR_W'($urandom_range(0, 31));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
